// File: rtl/debris_collision_checker.sv
// Purpose : compares the debris word in the player column against the ship lane;
//           tracks lives and dodge score, and gates the object shifter.
// Latency : every output is registered and moves on the edge that samples its inputs (1 cycle).
// Backpressure: the shifter is stalled by ShifterEnable=0 in IDLE/OVER, and GameOver is held until GameOverAck.
// Ports   : clk, rst (async, active-low); Start, ShapeIn[6:0] (active-low segments),
//           PlayerPos[1:0], DebrisDodge, GameOverAck in; ShifterEnable, Collision,
//           LivesLeft[2:0], Score[SCORE_W-1:0], GameOver out.
module debris_collision_checker #(
  parameter int LIVES   = 3,
  parameter int SCORE_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Start,
  input  logic [6:0]         ShapeIn,
  input  logic [1:0]         PlayerPos,
  input  logic               DebrisDodge,
  input  logic               GameOverAck,
  output logic               ShifterEnable,
  output logic               Collision,
  output logic [2:0]         LivesLeft,
  output logic [SCORE_W-1:0] Score,
  output logic               GameOver
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HIT = 2'd2, OVER = 2'd3} state_t;

  state_t             state, stateNext;
  logic [6:0]         shipMask;
  logic               hit;
  logic               blank;
  logic               collisionNext;
  logic [2:0]         livesNext;
  logic [SCORE_W-1:0] scoreNext;

  // Ship occupies one segment: top lane = a, middle = g, bottom = d.
  // Lane code 3 is not a real lane and is folded onto the middle.
  always_comb begin
    shipMask = 7'b1000000;
    case (PlayerPos)
      2'd0:    shipMask = 7'b0000001;
      2'd2:    shipMask = 7'b0001000;
      default: shipMask = 7'b1000000;
    endcase
  end

  // Segments are active-low, so a lit segment under the ship is a zero.
  assign hit   = |(~ShapeIn & shipMask);
  assign blank = (ShapeIn == 7'b1111111);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (Start) stateNext = PLAY;
      PLAY: if (hit) stateNext = (LivesLeft == 3'd1) ? OVER : HIT;
      // Invulnerable until the object that hit us has fully left the column.
      HIT:  if (blank) stateNext = PLAY;
      OVER: if (GameOverAck) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Next-value logic for the registered outputs
  always_comb begin
    collisionNext = 1'b0;
    livesNext     = LivesLeft;
    scoreNext     = Score;
    case (state)
      IDLE: begin
        if (Start) begin
          livesNext = 3'(LIVES);
          scoreNext = '0;
        end
      end
      PLAY: begin
        // A hit takes priority over a dodge arriving in the same cycle.
        if (hit) begin
          collisionNext = 1'b1;
          livesNext     = LivesLeft - 3'd1;
        end else if (DebrisDodge && (Score != {SCORE_W{1'b1}})) begin
          scoreNext = Score + SCORE_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Output registers. Enable and GameOver track the state being entered,
  // so they change on the same edge as the state itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ShifterEnable <= 1'b0;
      Collision     <= 1'b0;
      LivesLeft     <= 3'd0;
      Score         <= '0;
      GameOver      <= 1'b0;
    end else begin
      ShifterEnable <= (stateNext == PLAY) || (stateNext == HIT);
      Collision     <= collisionNext;
      LivesLeft     <= livesNext;
      Score         <= scoreNext;
      GameOver      <= (stateNext == OVER);
    end
  end

endmodule

// File: tb/tb_debris_collision_checker.sv
// Purpose : random and directed checking of debris_collision_checker with two score widths.
// Latency : expectations are queued one cycle ahead and matched by cycle tag.
// Backpressure: none; the monitor compares every cycle that has a queued expectation.
module tb_debris_collision_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       Start, DebrisDodge, GameOverAck;
  logic [6:0] ShapeIn;
  logic [1:0] PlayerPos;

  logic       shEnA, collA, goA, shEnB, collB, goB;
  logic [2:0] livesA, livesB;
  logic [9:0] scoreA;
  logic [1:0] scoreB;

  always #5 clk = ~clk;

  debris_collision_checker #(.LIVES(3), .SCORE_W(10)) dutA (
    .clk(clk), .rst(rst), .Start(Start), .ShapeIn(ShapeIn), .PlayerPos(PlayerPos),
    .DebrisDodge(DebrisDodge), .GameOverAck(GameOverAck),
    .ShifterEnable(shEnA), .Collision(collA), .LivesLeft(livesA), .Score(scoreA), .GameOver(goA));

  debris_collision_checker #(.LIVES(3), .SCORE_W(2)) dutB (
    .clk(clk), .rst(rst), .Start(Start), .ShapeIn(ShapeIn), .PlayerPos(PlayerPos),
    .DebrisDodge(DebrisDodge), .GameOverAck(GameOverAck),
    .ShifterEnable(shEnB), .Collision(collB), .LivesLeft(livesB), .Score(scoreB), .GameOver(goB));

  typedef struct {
    int cyc;
    int shEn, coll, lives, scA, scB, go;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model: game mode as a small integer, plain integer counters.
  // mode 0=waiting for start, 1=playing, 2=invulnerable, 3=game over
  int mMode, mLives, mScA, mScB;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] SEG_A = 7'b1111110;
  localparam logic [6:0] SEG_G = 7'b0111111;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, req);
    end
  endtask

  task automatic modelReset();
    mMode = 0; mLives = 0; mScA = 0; mScB = 0;
  endtask

  function automatic exp_t mkExp(input int c, input int coll);
    exp_t e;
    e.cyc   = c;
    e.shEn  = (mMode == 1 || mMode == 2) ? 1 : 0;
    e.coll  = coll;
    e.lives = mLives;
    e.scA   = mScA;
    e.scB   = mScB;
    e.go    = (mMode == 3) ? 1 : 0;
    return e;
  endfunction

  // Apply one cycle of inputs, advance the model, queue the expected outputs
  // for the coming edge. Entered and left at posedge+3.
  task automatic cycle(input logic st, input logic [6:0] shp, input logic [1:0] pos,
                       input logic dg, input logic ak);
    int seg;
    logic isHit;
    int coll;
    Start = st; ShapeIn = shp; PlayerPos = pos; DebrisDodge = dg; GameOverAck = ak;
    seg   = (pos == 2'd0) ? 0 : (pos == 2'd2) ? 3 : 6;
    isHit = (shp[seg] == 1'b0);
    coll  = 0;
    case (mMode)
      0: if (st) begin mMode = 1; mLives = 3; mScA = 0; mScB = 0; end
      1: begin
        if (isHit) begin
          coll   = 1;
          mLives = mLives - 1;
          mMode  = (mLives == 0) ? 3 : 2;
        end else if (dg) begin
          mScA = (mScA + 1 > 1023) ? 1023 : mScA + 1;
          mScB = (mScB + 1 > 3) ? 3 : mScB + 1;
        end
      end
      2: if (shp == BLANK) mMode = 1;
      default: if (ak) mMode = 0;
    endcase
    q.push_back(mkExp(cyc + 1, coll));
    @(posedge clk); #3;
  endtask

  task automatic checkZero(input string tag);
    chk({tag, "_shEnA"}, int'(shEnA), 0);
    chk({tag, "_collA"}, int'(collA), 0);
    chk({tag, "_livesA"}, int'(livesA), 0);
    chk({tag, "_scoreA"}, int'(scoreA), 0);
    chk({tag, "_goA"}, int'(goA), 0);
    chk({tag, "_scoreB"}, int'(scoreB), 0);
  endtask

  // Asynchronous reset mid-run: outputs must clear before any clock edge.
  task automatic doReset();
    rst = 1'b0;
    #1;
    checkZero("async_rst");
    q.delete();
    modelReset();
    for (int i = 0; i < 3; i++) q.push_back(mkExp(cyc + i, 0));
    @(posedge clk); #3;
    @(posedge clk); #3;
    rst = 1'b1;
  endtask

  always @(posedge clk) cyc++;

  // Monitor: compare whatever the DUTs present against the queued expectation.
  exp_t mon;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon = q.pop_front();
      if (mon.cyc == cyc) begin
        chk("ShifterEnable", int'(shEnA), mon.shEn);
        chk("Collision", int'(collA), mon.coll);
        chk("LivesLeft", int'(livesA), mon.lives);
        chk("Score10", int'(scoreA), mon.scA);
        chk("GameOver", int'(goA), mon.go);
        chk("Score2", int'(scoreB), mon.scB);
        chk("Collision_B", int'(collB), mon.coll);
        chk("GameOver_B", int'(goB), mon.go);
        chk("ShifterEnable_B", int'(shEnB), mon.shEn);
        chk("LivesLeft_B", int'(livesB), mon.lives);
      end else begin
        errors++;
        $display("FAIL stale_expectation cycle %0d: entry for cycle %0d never compared", cyc, mon.cyc);
      end
    end
  end

  initial begin
    logic [6:0] shp;
    rst = 1'b0; Start = 1'b0; ShapeIn = BLANK; PlayerPos = 2'd0;
    DebrisDodge = 1'b0; GameOverAck = 1'b0;
    modelReset();
    #1;
    checkZero("power_on_rst");
    @(posedge clk); #3;
    rst = 1'b1;

    // Reach Score=5 mid-game (narrow score saturates at 3), then reset.
    cycle(1, BLANK, 0, 0, 0);
    repeat (5) cycle(0, BLANK, 0, 1, 0);
    cycle(0, BLANK, 0, 0, 0);
    doReset();

    // Hit, invulnerability, scoring, simultaneous hit+dodge, game over.
    cycle(1, BLANK, 0, 0, 0);
    cycle(0, SEG_A, 0, 0, 0);   // hit: lives 3->2
    cycle(0, SEG_A, 0, 1, 0);   // dodge while invulnerable: no score
    cycle(0, BLANK, 0, 0, 0);   // back to play
    cycle(0, SEG_G, 2, 0, 0);   // g lit, ship at d: miss
    cycle(0, SEG_G, 2, 1, 0);   // dodge: score 1
    cycle(0, SEG_G, 0, 0, 0);   // ship at a: miss
    cycle(0, SEG_G, 1, 0, 0);   // move into object: hit, lives 1
    cycle(0, BLANK, 1, 0, 0);
    cycle(0, SEG_A, 0, 1, 0);   // hit + dodge together: lives 0, over, no score
    cycle(1, SEG_A, 0, 0, 0);   // start ignored in over
    cycle(0, BLANK, 0, 0, 0);
    cycle(1, BLANK, 0, 0, 1);   // ack wins over start
    cycle(0, BLANK, 0, 0, 0);
    cycle(1, BLANK, 0, 0, 0);   // new game: lives 3, score 0
    cycle(0, BLANK, 3, 0, 0);

    // Randomized play.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        doReset();
      end else begin
        case ($urandom_range(0, 3))
          0, 1: shp = BLANK;
          2:    shp = BLANK & ~(7'd1 << $urandom_range(0, 6));
          default: shp = 7'($urandom);
        endcase
        cycle(1'($urandom_range(0, 15) == 0), shp, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0));
      end
    end

    cycle(0, BLANK, 0, 0, 0);
    @(negedge clk); #1;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
